// File: rtl/rtf64_shift_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rtf64pkg: shared types for the rtf64 pipelined shift/rotate unit.
//
// Contents:
//   shift_op_t  - shift operation encoding (value 7 is reserved, acts as ASL)
//   shift_sz_t  - element size select, element width = WID >> sz
//   shift_ctl_t - width-independent control fields that travel with every
//                 pipeline payload (op, size, simd, carry in/out, valid)
//   is_left     - true for operations that move bits toward the MSB
// ---------------------------------------------------------------------------
package rtf64pkg;

  typedef enum logic [2:0] {
    ASL  = 3'd0,
    LSR  = 3'd1,
    ASR  = 3'd2,
    ROL  = 3'd3,
    ROR  = 3'd4,
    ASLX = 3'd5,
    LSRX = 3'd6
  } shift_op_t;

  typedef enum logic [1:0] {
    SZ_FULL = 2'd0,
    SZ_HALF = 2'd1,
    SZ_QTR  = 2'd2,
    SZ_OCT  = 2'd3
  } shift_sz_t;

  // The data-width dependent payload fields (data, remaining amount, merge
  // source, tag) are declared next to these in the modules, because package
  // types cannot depend on a module parameter.
  typedef struct packed {
    shift_op_t op;
    shift_sz_t sz;
    logic      simd;
    logic      cin;
    logic      cout;
    logic      valid;
  } shift_ctl_t;

  // The reserved encoding falls into the left group so that it behaves as ASL.
  function automatic logic is_left(input shift_op_t op);
    return !(op inside {LSR, ASR, ROR, LSRX});
  endfunction

endpackage

// File: rtl/rtf64_shift_stage.sv
// ---------------------------------------------------------------------------
// rtf64_shift_stage: one slice of the shift pipeline.
//
// Applies shift levels FIRST_LVL .. FIRST_LVL+NUM_LVL-1 (level k moves by
// 2**k) inside each element, then optionally performs the final
// normalisation (d merge), then either registers or bypasses the payload.
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset, clears the stored payload
//   en        load enable; low holds the stored payload (pipeline stall)
//   payload_d incoming payload, flattened
//   payload_q outgoing payload, flattened
// ---------------------------------------------------------------------------
module rtf64_shift_stage
  import rtf64pkg::*;
#(
  parameter int WID       = 64,
  parameter int TAGW      = 6,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1,
  parameter bit NORM      = 1'b0,
  parameter bit REG       = 1'b1,
  localparam int PW       = 2 * WID + $clog2(WID) + TAGW + $bits(shift_ctl_t)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [PW-1:0] payload_d,
  output logic [PW-1:0] payload_q
);

  localparam int LW = $clog2(WID);

  typedef logic [WID-1:0] data_t;
  typedef logic [LW-1:0]  amt_t;

  typedef struct packed {
    data_t           data;
    amt_t            amt;
    data_t           d;
    logic [TAGW-1:0] tag;
    shift_ctl_t      ctl;
  } payload_t;

  payload_t nxt;

  function automatic logic [LW-1:0] bit_idx(input int v);
    return LW'(v);
  endfunction

  // One shift level. Every op is a funnel inside its own element; only the
  // fill source for vacated positions differs. The carry is inserted at the
  // first level that actually moves, then cleared so later levels fill
  // zeros and simply carry it along to bit n-1 (left) or bit E-n (right).
  // cout tracks the last bit that left element 0; for rotates that bit is
  // exactly the one that lands on result bit 0 / bit E-1.
  function automatic payload_t apply_level(input payload_t p, input int k);
    payload_t r;
    int       e;
    int       s;
    int       pos;
    logic     left;
    r    = p;
    e    = WID >> p.ctl.sz;
    s    = 1 << k;
    left = is_left(p.ctl.op);
    for (int i = 0; i < WID; i++) begin
      pos = i & (e - 1);
      if (left) begin
        if (pos >= s) begin
          r.data[bit_idx(i)] = p.data[bit_idx(i - s)];
        end else begin
          case (p.ctl.op)
            ROL:     r.data[bit_idx(i)] = p.data[bit_idx(i - s + e)];
            ASLX:    r.data[bit_idx(i)] = (pos == s - 1) ? p.ctl.cin : 1'b0;
            default: r.data[bit_idx(i)] = 1'b0;
          endcase
        end
      end else begin
        if (pos + s < e) begin
          r.data[bit_idx(i)] = p.data[bit_idx(i + s)];
        end else begin
          case (p.ctl.op)
            ROR:     r.data[bit_idx(i)] = p.data[bit_idx(i + s - e)];
            ASR:     r.data[bit_idx(i)] = p.data[bit_idx(i - pos + e - 1)];
            LSRX:    r.data[bit_idx(i)] = (pos == e - s) ? p.ctl.cin : 1'b0;
            default: r.data[bit_idx(i)] = 1'b0;
          endcase
        end
      end
    end
    r.ctl.cout = left ? p.data[bit_idx(e - s)] : p.data[bit_idx(s - 1)];
    r.ctl.cin  = 1'b0;
    r.amt      = p.amt & ~(amt_t'(1) << k);
    return r;
  endfunction

  // Shift levels of this slice, then the optional final merge of d_i above
  // element 0 for non-SIMD sub-width operations.
  always_comb begin
    data_t lane0;
    lane0 = '0;
    nxt   = payload_t'(payload_d);
    for (int k = FIRST_LVL; k < FIRST_LVL + NUM_LVL; k++) begin
      if (((nxt.amt >> k) & amt_t'(1)) != '0) begin
        nxt = apply_level(nxt, k);
      end
    end
    if (NORM && !nxt.ctl.simd && nxt.ctl.sz != SZ_FULL) begin
      lane0    = (data_t'(1) << (WID >> nxt.ctl.sz)) - data_t'(1);
      nxt.data = (nxt.data & lane0) | (nxt.d & ~lane0);
    end
  end

  generate
    if (REG) begin : g_reg
      payload_t q;

      // Pipeline register; a stall freezes it, bubbles included.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q <= '0;
        end else if (en) begin
          q <= nxt;
        end
      end

      assign payload_q = q;
    end else begin : g_bypass
      assign payload_q = nxt;
    end
  endgenerate

endmodule

// File: rtl/rtf64_shift_pipe.sv
// ---------------------------------------------------------------------------
// rtf64_shift_pipe: pipelined shift/rotate unit for the rtf64 execute stage.
//
// Latency STAGES cycles, one operation per cycle, valid/ready on both sides.
// The $clog2(WID) shift levels are spread evenly over STAGES slices; the
// last slice also performs the d_i merge so all outputs come from flops.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   op_i, sz_i, simd_i       operation, element size, SIMD select
//   a_i, amt_i, d_i, cin_i   operand, amount, merge source, carry in
//   tag_i                    opaque tag carried with the operation
//   res_valid_o/res_ready_i  result handshake
//   res_o, cout_o, tag_o     result, carry out of element 0, result tag
// ---------------------------------------------------------------------------
module rtf64_shift_pipe
  import rtf64pkg::*;
#(
  parameter int WID    = 64,
  parameter int STAGES = 2,
  parameter int TAGW   = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0]             op_i,
  input  logic [1:0]             sz_i,
  input  logic                   simd_i,
  input  logic [WID-1:0]         a_i,
  input  logic [$clog2(WID)-1:0] amt_i,
  input  logic [WID-1:0]         d_i,
  input  logic                   cin_i,
  input  logic [TAGW-1:0]        tag_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [WID-1:0]         res_o,
  output logic                   cout_o,
  output logic [TAGW-1:0]        tag_o
);

  localparam int LW      = $clog2(WID);
  localparam int LVL_PER = (LW + STAGES - 1) / STAGES;

  typedef logic [WID-1:0] data_t;
  typedef logic [LW-1:0]  amt_t;

  typedef struct packed {
    data_t           data;
    amt_t            amt;
    data_t           d;
    logic [TAGW-1:0] tag;
    shift_ctl_t      ctl;
  } payload_t;

  localparam int PW = $bits(payload_t);

  logic [PW-1:0] pipe [STAGES+1];
  payload_t      head;
  payload_t      tail;
  logic          stall;
  logic          unused_tail;

  assign stall       = res_valid_o && !res_ready_i;
  assign req_ready_o = !stall && rst_ni;

  // Entry payload. The amount is reduced modulo the element width here so
  // the slices never see a level wider than an element.
  always_comb begin
    head           = '0;
    head.data      = a_i;
    head.amt       = amt_i & amt_t'((WID >> sz_i) - 1);
    head.d         = d_i;
    head.tag       = tag_i;
    head.ctl.op    = shift_op_t'(op_i);
    head.ctl.sz    = shift_sz_t'(sz_i);
    head.ctl.simd  = simd_i;
    head.ctl.cin   = cin_i;
    head.ctl.cout  = 1'b0;
    head.ctl.valid = req_valid_i && req_ready_o;
  end

  assign pipe[0] = head;

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int FIRST = s * LVL_PER;
      localparam int LAST  = (FIRST + LVL_PER < LW) ? FIRST + LVL_PER : LW;
      localparam int NUM   = (LAST > FIRST) ? LAST - FIRST : 0;

      rtf64_shift_stage #(
        .WID      (WID),
        .TAGW     (TAGW),
        .FIRST_LVL(FIRST),
        .NUM_LVL  (NUM),
        .NORM     (s == STAGES - 1),
        .REG      (1'b1)
      ) u_stage (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .en       (!stall),
        .payload_d(pipe[s]),
        .payload_q(pipe[s+1])
      );
    end
  endgenerate

  assign tail        = payload_t'(pipe[STAGES]);
  assign res_valid_o = tail.ctl.valid;
  assign res_o       = tail.data;
  assign cout_o      = tail.ctl.cout;
  assign tag_o       = tail.tag;

  // Fields that are spent by the time the payload leaves the last slice.
  assign unused_tail = ^{tail.amt, tail.d, tail.ctl.op, tail.ctl.sz,
                         tail.ctl.simd, tail.ctl.cin};

endmodule

// File: tb/tb_rtf64_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_rtf64_shift_pipe: directed self-checking bench for rtf64_shift_pipe
// with WID=64, STAGES=2, TAGW=6. Expected values are hand-computed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rtf64_shift_pipe;

  localparam int WID    = 64;
  localparam int STAGES = 2;
  localparam int TAGW   = 6;

  localparam logic [2:0] OP_ASL  = 3'd0;
  localparam logic [2:0] OP_LSR  = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ASLX = 3'd5;
  localparam logic [2:0] OP_LSRX = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  logic            clk       = 1'b0;
  logic            rstN      = 1'b0;
  logic            reqValid  = 1'b0;
  logic            reqReady;
  logic [2:0]      op        = 3'd0;
  logic [1:0]      sz        = 2'd0;
  logic            simd      = 1'b0;
  logic [63:0]     a         = 64'd0;
  logic [5:0]      amt       = 6'd0;
  logic [63:0]     d         = 64'd0;
  logic            cin       = 1'b0;
  logic [TAGW-1:0] tagIn     = '0;
  logic            resValid;
  logic            resReady  = 1'b1;
  logic [63:0]     res;
  logic            cout;
  logic [TAGW-1:0] tagOut;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  rtf64_shift_pipe #(
    .WID   (WID),
    .STAGES(STAGES),
    .TAGW  (TAGW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .req_valid_i(reqValid),
    .req_ready_o(reqReady),
    .op_i       (op),
    .sz_i       (sz),
    .simd_i     (simd),
    .a_i        (a),
    .amt_i      (amt),
    .d_i        (d),
    .cin_i      (cin),
    .tag_i      (tagIn),
    .res_valid_o(resValid),
    .res_ready_i(resReady),
    .res_o      (res),
    .cout_o     (cout),
    .tag_o      (tagOut)
  );

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the pipe takes it (bounded).
  task automatic applyStimulus(input logic [2:0] opV, input logic [1:0] szV,
                               input logic simdV, input logic [63:0] aV,
                               input logic [5:0] amtV, input logic [63:0] dV,
                               input logic cinV, input logic [TAGW-1:0] tagV);
    bit accepted;
    accepted = 1'b0;
    op       = opV;
    sz       = szV;
    simd     = simdV;
    a        = aV;
    amt      = amtV;
    d        = dV;
    cin      = cinV;
    tagIn    = tagV;
    reqValid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      accepted = reqReady;
      nextCycle();
    end
    reqValid = 1'b0;
    checkOutput("accept", 64'(accepted), 64'd1);
  endtask

  // Single operation with latency check: nothing one edge after accept,
  // the result on the next.
  task automatic runOp(input string name, input logic [2:0] opV,
                       input logic [1:0] szV, input logic simdV,
                       input logic [63:0] aV, input logic [5:0] amtV,
                       input logic [63:0] dV, input logic cinV,
                       input logic [TAGW-1:0] tagV,
                       input logic [63:0] expRes, input logic expCout);
    applyStimulus(opV, szV, simdV, aV, amtV, dV, cinV, tagV);
    checkOutput({name, " early valid"}, 64'(resValid), 64'd0);
    nextCycle();
    checkOutput({name, " valid"}, 64'(resValid), 64'd1);
    checkOutput({name, " res"}, res, expRes);
    checkOutput({name, " cout"}, 64'(cout), 64'(expCout));
    checkOutput({name, " tag"}, 64'(tagOut), 64'(tagV));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    rstN = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("reset ready", 64'(reqReady), 64'd0);
    checkOutput("reset valid", 64'(resValid), 64'd0);
    checkOutput("reset res", res, 64'd0);
    checkOutput("reset tag", 64'(tagOut), 64'd0);
    checkOutput("reset cout", 64'(cout), 64'd0);
    rstN = 1'b1;
    nextCycle();
    checkOutput("release ready", 64'(reqReady), 64'd1);

    // Directed operations
    runOp("asl", OP_ASL, 2'd0, 1'b0, 64'h8000_0000_0000_0001, 6'd1, 64'd0, 1'b0,
          6'd1, 64'h0000_0000_0000_0002, 1'b1);
    runOp("asr q", OP_ASR, 2'd2, 1'b0, 64'h0000_0000_0000_8000, 6'd4,
          64'hFFFF_FFFF_FFFF_0000, 1'b0, 6'd2, 64'hFFFF_FFFF_FFFF_F800, 1'b0);
    runOp("rol oct 1", OP_ROL, 2'd3, 1'b1, 64'h8101_0000_0000_0080, 6'd1, 64'd0,
          1'b0, 6'd3, 64'h0302_0000_0000_0001, 1'b1);
    runOp("rol oct 9", OP_ROL, 2'd3, 1'b1, 64'h8101_0000_0000_0080, 6'd9, 64'd0,
          1'b0, 6'd4, 64'h0302_0000_0000_0001, 1'b1);
    runOp("lsrx 4", OP_LSRX, 2'd0, 1'b0, 64'h10, 6'd4, 64'd0, 1'b1,
          6'd5, 64'h1000_0000_0000_0001, 1'b0);
    runOp("lsrx 0", OP_LSRX, 2'd0, 1'b0, 64'h10, 6'd0, 64'd0, 1'b1,
          6'd6, 64'h0000_0000_0000_0010, 1'b0);
    runOp("ror", OP_ROR, 2'd0, 1'b0, 64'h1, 6'd1, 64'd0, 1'b0,
          6'd7, 64'h8000_0000_0000_0000, 1'b1);
    runOp("aslx", OP_ASLX, 2'd0, 1'b0, 64'h1, 6'd3, 64'd0, 1'b1,
          6'd8, 64'h0000_0000_0000_000C, 1'b0);
    runOp("lsr half", OP_LSR, 2'd1, 1'b1, 64'h8000_0000_0000_0018, 6'd4, 64'd0,
          1'b0, 6'd9, 64'h0800_0000_0000_0001, 1'b1);
    runOp("rsvd oct", OP_RSVD, 2'd3, 1'b1, 64'h0102_0304_0506_0708, 6'd5, 64'd0,
          1'b0, 6'd10, 64'h2040_6080_A0C0_E000, 1'b1);
    runOp("asr 63", OP_ASR, 2'd0, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'd0,
          1'b0, 6'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    runOp("rol merge", OP_ROL, 2'd1, 1'b0, 64'h1234_5678_8000_0001, 6'd1,
          64'hAAAA_AAAA_0000_0000, 1'b0, 6'd12, 64'hAAAA_AAAA_0000_0003, 1'b1);
    nextCycle();

    // Back-pressure: four back-to-back ASL ops, amount = tag, result 1<<tag
    begin
      int sent      = 0;
      int got       = 0;
      int stallLeft = 0;
      bit stallDone = 1'b0;
      op   = OP_ASL;
      sz   = 2'd0;
      simd = 1'b0;
      a    = 64'd1;
      d    = 64'd0;
      cin  = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        if (resValid && !stallDone) begin
          stallLeft = 3;
          stallDone = 1'b1;
        end
        resReady = (stallLeft == 0);
        reqValid = (sent < 4);
        tagIn    = TAGW'(sent);
        amt      = 6'(sent);
        #1;
        if (stallLeft > 0) begin
          checkOutput("bp ready low", 64'(reqReady), 64'd0);
          checkOutput("bp valid held", 64'(resValid), 64'd1);
          checkOutput("bp res held", res, 64'd1 << got);
          checkOutput("bp tag held", 64'(tagOut), 64'(got));
          stallLeft--;
        end
        if (resValid && resReady) begin
          checkOutput("bp tag order", 64'(tagOut), 64'(got));
          checkOutput("bp res", res, 64'd1 << got);
          got++;
        end
        if (reqValid && reqReady) begin
          sent++;
        end
        @(posedge clk);
        #1;
      end
      reqValid = 1'b0;
      resReady = 1'b1;
      checkOutput("bp delivered", 64'(got), 64'd4);
      checkOutput("bp sent", 64'(sent), 64'd4);
    end
    nextCycle();
    nextCycle();
    checkOutput("bp no extra", 64'(resValid), 64'd0);

    // Reset with two operations in flight, plus a request during reset
    op       = OP_ASL;
    sz       = 2'd0;
    a        = 64'd3;
    amt      = 6'd1;
    tagIn    = 6'd5;
    reqValid = 1'b1;
    nextCycle();
    tagIn = 6'd6;
    nextCycle();
    checkOutput("inflight valid", 64'(resValid), 64'd1);
    rstN  = 1'b0;
    tagIn = 6'd7;
    nextCycle();
    checkOutput("midreset valid", 64'(resValid), 64'd0);
    checkOutput("midreset res", res, 64'd0);
    checkOutput("midreset tag", 64'(tagOut), 64'd0);
    checkOutput("midreset ready", 64'(reqReady), 64'd0);
    rstN     = 1'b1;
    reqValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("no stale", 64'(resValid), 64'd0);
    end
    checkOutput("post reset ready", 64'(reqReady), 64'd1);
    runOp("post reset", OP_LSR, 2'd0, 1'b0, 64'hF0, 6'd4, 64'd0, 1'b0,
          6'd9, 64'h0000_0000_0000_000F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
